mem_port_arbiter: RTL and testbench

- Arbitrates one shared unified memory port between the instruction-fetch requester (port 0) and the load/store data requester (port 1).
- Used by the multicycle/shared-memory variant of the RISC-V core.
- Sequences each access through a handshake, latches the winner's request, and drives grant_sel, the selector of the 2:1 address/data multiplexers in front of the memory.
- Round-robin fairness and a watchdog timeout on the memory acknowledge.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory port and the arbiter.
// The arbiter uses the master modport; requesters and memory use the slave modport.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ack;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    logic                  grant_sel;
    logic                  busy;
    logic                  err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, grant_sel, busy, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, grant_sel, busy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and load/store (port 1), with a watchdog on the memory acknowledge.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned CNT_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_nxt;
    logic                  last_owner_q, last_owner_nxt;
    logic                  grant_q, grant_nxt;
    logic                  mem_req_q, mem_req_nxt;
    logic                  mem_we_q, mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_nxt;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_nxt;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_nxt;
    logic                  if_ack_q, if_ack_nxt;
    logic                  d_ack_q, d_ack_nxt;
    logic                  busy_q, busy_nxt;
    logic                  err_q, err_nxt;
    logic                  pick;
    logic                  finish;
    logic [DATA_WIDTH-1:0] resp_data;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
            grant_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            last_owner_q <= last_owner_nxt;
            grant_q      <= grant_nxt;
            mem_req_q    <= mem_req_nxt;
            mem_we_q     <= mem_we_nxt;
            mem_addr_q   <= mem_addr_nxt;
            mem_wdata_q  <= mem_wdata_nxt;
            if_rdata_q   <= if_rdata_nxt;
            d_rdata_q    <= d_rdata_nxt;
            if_ack_q     <= if_ack_nxt;
            d_ack_q      <= d_ack_nxt;
            busy_q       <= busy_nxt;
            err_q        <= err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state_q;
        cnt_nxt        = cnt_q;
        last_owner_nxt = last_owner_q;
        grant_nxt      = grant_q;
        mem_we_nxt     = mem_we_q;
        mem_addr_nxt   = mem_addr_q;
        mem_wdata_nxt  = mem_wdata_q;
        if_rdata_nxt   = if_rdata_q;
        d_rdata_nxt    = d_rdata_q;
        if_ack_nxt     = 1'b0;
        d_ack_nxt      = 1'b0;
        err_nxt        = 1'b0;
        pick           = 1'b0;
        finish         = 1'b0;
        resp_data      = '0;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // On a tie the port that did not own the previous access wins
                    pick           = (bus.if_req && bus.d_req) ? ~last_owner_q : bus.d_req;
                    grant_nxt      = pick;
                    last_owner_nxt = pick;
                    mem_we_nxt     = pick ? bus.d_we : 1'b0;
                    mem_addr_nxt   = pick ? bus.d_addr : bus.if_addr;
                    mem_wdata_nxt  = pick ? bus.d_wdata : '0;
                    cnt_nxt        = '0;
                    state_nxt      = ACCESS;
                end
            end
            ACCESS: begin
                // An ack arriving on the last allowed cycle still counts as success
                if (bus.mem_ack) begin
                    finish    = 1'b1;
                    resp_data = bus.mem_rdata;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt   = cnt_q + CNT_WIDTH'(1);
                end
                if (finish) begin
                    state_nxt = RESP;
                    if (grant_q) begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = resp_data;
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = resp_data;
                    end
                end
            end
            RESP: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        mem_req_nxt = (state_nxt == ACCESS);
        busy_nxt    = (state_nxt != IDLE);
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.grant_sel = grant_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requesters and memory are driven per transaction
// and checked against a transaction-level model of arbitration, latency and timeout.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          TO = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: pending requests per port, round-robin owner memory, last returned data
    bit          pend [2];
    logic [31:0] paddr [2];
    bit          pwe;
    logic [31:0] pwdata;
    logic [31:0] exp_rdata [2];
    int          last_owner_m;
    logic        exp_grant;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.if_req  = pend[0];
        bus.if_addr = paddr[0];
        bus.d_req   = pend[1];
        bus.d_addr  = paddr[1];
        bus.d_we    = pwe;
        bus.d_wdata = pwdata;
    endtask

    task automatic model_reset();
        last_owner_m = 1;
        exp_grant    = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic check_rdata(input string tag);
        check({tag, "_if_rdata"}, bus.if_rdata, exp_rdata[0]);
        check({tag, "_d_rdata"}, bus.d_rdata, exp_rdata[1]);
    endtask

    // Called at the negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
    // delay = ACCESS cycle carrying mem_ack (1 = first); delay > TO means never acknowledged.
    task automatic step(input bit new_if, input bit new_d, input int delay, input logic [31:0] rd);
        int          owner;
        int          other;
        logic [31:0] eaddr, ewdata;
        logic        ewe, eerr;
        check("idle_mem_req", 32'(bus.mem_req), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        check("idle_err", 32'(bus.err), 32'd0);
        check("idle_grant", 32'(bus.grant_sel), 32'(exp_grant));
        check_rdata("idle");
        if (new_if && !pend[0]) begin
            pend[0]  = 1'b1;
            paddr[0] = $urandom;
        end
        if (new_d && !pend[1]) begin
            pend[1]  = 1'b1;
            paddr[1] = $urandom;
            pwe      = 1'($urandom_range(0, 1));
            pwdata   = $urandom;
        end
        drive_reqs();
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        if (!pend[0] && !pend[1]) begin
            @(negedge clk);
            return;
        end
        if (pend[0] && pend[1]) owner = (last_owner_m == 1) ? 0 : 1;
        else                    owner = pend[1] ? 1 : 0;
        other        = 1 - owner;
        last_owner_m = owner;
        exp_grant    = 1'(owner);
        eaddr        = paddr[owner];
        ewe          = (owner == 1) ? pwe : 1'b0;
        ewdata       = (owner == 1) ? pwdata : 32'd0;
        @(negedge clk);
        for (int k = 1; k <= TO; k++) begin
            check("acc_mem_req", 32'(bus.mem_req), 32'd1);
            check("acc_busy", 32'(bus.busy), 32'd1);
            check("acc_grant", 32'(bus.grant_sel), 32'(exp_grant));
            check("acc_addr", bus.mem_addr, eaddr);
            check("acc_we", 32'(bus.mem_we), 32'(ewe));
            check("acc_wdata", bus.mem_wdata, ewdata);
            check("acc_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
            bus.mem_ack   = (k == delay) ? 1'b1 : 1'b0;
            bus.mem_rdata = (k == delay) ? rd : $urandom;
            // Owner's request lines wander; the latched transaction must not change
            if (owner == 1) begin
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
                bus.d_we    = 1'($urandom_range(0, 1));
            end else begin
                bus.if_addr = $urandom;
            end
            @(negedge clk);
            if (k == delay) break;
        end
        eerr             = (delay < 1 || delay > TO);
        exp_rdata[owner] = eerr ? 32'd0 : rd;
        check("resp_mem_req", 32'(bus.mem_req), 32'd0);
        check("resp_busy", 32'(bus.busy), 32'd1);
        check("resp_err", 32'(bus.err), 32'(eerr));
        check("resp_grant", 32'(bus.grant_sel), 32'(exp_grant));
        check("resp_owner_ack", 32'((owner == 1) ? bus.d_ack : bus.if_ack), 32'd1);
        check("resp_other_ack", 32'((other == 1) ? bus.d_ack : bus.if_ack), 32'd0);
        check_rdata("resp");
        pend[owner]  = 1'b0;
        drive_reqs();
        bus.mem_ack  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        pend[0]       = 1'b0;
        pend[1]       = 1'b0;
        paddr[0]      = '0;
        paddr[1]      = '0;
        pwe           = 1'b0;
        pwdata        = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        drive_reqs();
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({bus.mem_req, bus.mem_we, bus.if_ack, bus.d_ack,
                                  bus.grant_sel, bus.busy, bus.err}), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_rdata("rst");
        reset = 1'b0;

        // Fetch only, one memory wait cycle
        pend[0]  = 1'b1;
        paddr[0] = 32'h0000_0040;
        step(1'b0, 1'b0, 2, 32'h0051_0093);

        // Continuous dual demand from reset: grants alternate fetch, data, ...
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (6) step(1'b1, 1'b1, 1, $urandom);

        // Data store only
        pend[1]  = 1'b1;
        paddr[1] = 32'h1001_0000;
        pwe      = 1'b1;
        pwdata   = 32'hDEAD_BEEF;
        step(1'b0, 1'b0, 1, $urandom);

        // Timeout on a load, then a clean access; ack exactly on the last allowed cycle
        pend[1]  = 1'b1;
        paddr[1] = 32'h2000_0010;
        pwe      = 1'b0;
        step(1'b0, 1'b0, TO + 1, $urandom);
        step(1'b0, 1'b1, 1, $urandom);
        step(1'b1, 1'b0, TO, $urandom);

        // mem_ack noise with nothing pending
        repeat (4) step(1'b0, 1'b0, 1, $urandom);

        // Reset in the second ACCESS cycle of a data access
        pend[1]     = 1'b1;
        paddr[1]    = $urandom;
        pwe         = 1'b1;
        pwdata      = $urandom;
        drive_reqs();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("mid_acc1_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        check("mid_acc2_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        step(1'b1, 1'b0, 1, $urandom);
        step(1'b0, 1'b0, 1, $urandom);

        // Random traffic
        repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, TO + 1)), $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
